// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bundle for seq_divider
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, 2W/W -> W quotient and W remainder, one bit per clock
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // r_q always holds a value below the divisor, so the shifted partial remainder
  // fits in WIDTH+1 bits and the trial MSB is a clean sign bit.
  always_comb begin
    r_sh   = {r_q, q_q[WIDTH-1]};
    trial  = r_sh - {1'b0, dvs_q};
    r_next = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      r_q             <= '0;
      q_q             <= '0;
      dvs_q           <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            dvs_q           <= bus.divisor;
            bus.div_by_zero <= (bus.divisor == '0);
            bus.overflow    <= (bus.divisor != '0) &&
                               (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
            if ((bus.divisor == '0) || (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor)) begin
              // Saturated result; quotient cannot be represented.
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend[WIDTH-1:0];
              bus.done      <= 1'b1;
              bus.busy      <= 1'b0;
              state         <= DONE;
            end else begin
              r_q      <= bus.dividend[2*WIDTH-1:WIDTH];
              q_q      <= bus.dividend[WIDTH-1:0];
              cnt      <= '0;
              bus.busy <= 1'b1;
              state    <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          r_q <= r_next;
          q_q <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bus.quotient  <= q_next;
            bus.remainder <= r_next;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider: directed, error, back-to-back and reset cases
module tb_seq_divider;
  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  seq_divider_if #(.WIDTH(16)) bus ();

  seq_divider #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", {16'd0, bus.quotient}, {16'd0, e.q});
        chk("remainder", {16'd0, bus.remainder}, {16'd0, e.r});
        chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
        chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
      end
    end
  end

  // Drive start for one edge; caller is mid-cycle. Returns #1 after the accept edge.
  task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs,
                       input logic [15:0] q, input logic [15:0] r,
                       input logic dbz, input logic ovf);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
    sb.push_back(e);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts edges from the current point until done, and busy samples along the way.
  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int n = 0;
    int bc = 0;
    while (!bus.done && n < 200) begin
      if (bus.busy) bc++;
      @(posedge clk);
      #1 n++;
    end
    chk({name, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_busy_cycles"}, bc, exp_busy);
  endtask

  task automatic run_op(input string name, input logic [31:0] dvd, input logic [15:0] dvs,
                        input logic [15:0] q, input logic [15:0] r,
                        input logic dbz, input logic ovf, input int lat);
    issue(dvd, dvs, q, r, dbz, ovf);
    wait_done(name, lat, lat);
  endtask

  initial begin
    logic [31:0] a, b, rr;
    int dn;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #2;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_quotient", {16'd0, bus.quotient}, 32'd0);
    chk("rst_remainder", {16'd0, bus.remainder}, 32'd0);
    chk("rst_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("d100_7", 32'd100, 16'd7, 16'h000E, 16'd2, 1'b0, 1'b0, 16);
    run_op("max", 32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16);
    for (int i = 0; i < 200; i++) begin
      a  = 32'($urandom_range(0, 65535));
      b  = 32'($urandom_range(1, 65535));
      rr = 32'($urandom_range(0, 32'(b) - 1));
      run_op("rand", a * b + rr, b[15:0], a[15:0], rr[15:0], 1'b0, 1'b0, 16);
    end

    // Error paths complete in the cycle after the accept edge with busy never high.
    run_op("dbz", 32'h1234_5678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1'b0, 0);
    run_op("ovf", 32'h0001_0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);

    // A start pulse during CALC must be ignored.
    issue(32'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 16'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("ignored", 11, 11);
    // Back-to-back accept in the DONE cycle.
    run_op("b2b", 32'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b0, 16);

    // Reset in the middle of CALC abandons the operation.
    issue(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_quotient", {16'd0, bus.quotient}, 32'd0);
    chk("mid_rst_remainder", {16'd0, bus.remainder}, 32'd0);
    chk("mid_rst_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (bus.done) dn++;
    end
    chk("no_done_after_rst", dn, 0);
    run_op("post_rst", 32'd100, 16'd7, 16'h000E, 16'd2, 1'b0, 1'b0, 16);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse of the team's combinational 16x16 shift-add multiplier.
- Takes a 2W-bit dividend (e.g. a multiplier product) and a W-bit divisor.
- Produces a W-bit quotient and a W-bit remainder, one quotient bit per clock.
- start/busy/done handshake; sits beside the multiplier in the arithmetic datapath.

Parameters:
- WIDTH, 16, width of divisor, quotient and remainder; dividend is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on a rising edge only in IDLE or DONE
- dividend  input  2*WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  high while iterating (CALC)
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  registered quotient; held until the next accepted start
- remainder  output  WIDTH  registered remainder; held until the next accepted start
- div_by_zero  output  1  last accepted operation had divisor==0
- overflow  output  1  last accepted operation's quotient does not fit in WIDTH bits

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous, active-low (rst_n).
  - While rst_n=0: state=IDLE; busy, done, quotient, remainder, div_by_zero, overflow and the iteration counter all 0.
  - Reset mid-operation abandons the operation; no done is produced.
- States: IDLE, CALC, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE.
  - On acceptance: operands are latched; div_by_zero and overflow are cleared or set as below.
  - start in CALC is ignored; latched operands are not disturbed.
- Error checks (at the accept edge E0), in priority order:
  - divisor==0: next state DONE; div_by_zero=1, overflow=0; quotient={WIDTH{1}}; remainder=dividend[WIDTH-1:0].
  - Otherwise, if dividend[2W-1:W] >= divisor: next state DONE; overflow=1; quotient={WIDTH{1}}; remainder=dividend[WIDTH-1:0].
  - Either way, done is high in the cycle after E0.
- Normal path:
  - Partial remainder R (WIDTH+1 bits) is loaded with dividend[2W-1:W]; shift register Q is loaded with dividend[W-1:0]; counter=0; state CALC; busy=1.
  - Each CALC edge:
    - {R,Q} shifts left 1.
    - trial = R - {1'b0,divisor} at WIDTH+1 bits.
    - If trial is non-negative (MSB 0): R=trial and Q[0]=1; else R is kept and Q[0]=0.
    - Counter increments.
  - On the edge completing iteration WIDTH (edge E_WIDTH):
    - quotient=Q and remainder=R[WIDTH-1:0] are registered;
    - state DONE; busy=0; done=1.
  - Latency: done is high exactly WIDTH edges after E0; busy is high for exactly WIDTH cycles.
- Invariant for non-error operations: quotient*divisor + remainder == dividend; remainder < divisor.
- DONE state:
  - Lasts one cycle; done=1 only there.
  - Next state is IDLE, or CALC/DONE if start is accepted in that cycle (back-to-back, no bubble).
- Outputs hold their last values in IDLE.
- Error flags are registered and stay valid until the next accepted start.

Test Plan:
- dividend=100, divisor=7 -> quotient=14 (0x000E), remainder=2; done exactly 16 edges after the start edge; busy high for 16 cycles.
- dividend=0xFFFE_0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0; repeat with 200 random (a,b) pairs where dividend=a*b+r, r<b, b!=0 -> quotient=a, remainder=r.
- divisor=0, dividend=0x1234_5678 -> div_by_zero=1, quotient=0xFFFF, remainder=0x5678; done 1 cycle after the start edge; busy never high.
- dividend=0x0001_0000, divisor=1 -> overflow=1, div_by_zero=0, quotient=0xFFFF, remainder=0x0000; done 1 cycle after the start edge.
- Busy and back-to-back starts:
  - Start 1000/10, then pulse start with 50/5 during CALC -> ignored; result quotient=100, remainder=0.
  - Start 50/5 in the done cycle -> accepted; second done 16 edges later with quotient=10.
- Reset during CALC:
  - Drop rst_n at iteration 8, between edges -> busy, done, quotient, remainder and flags go to 0 immediately; no done pulse.
  - After release, 100/7 -> quotient=14, remainder=2.
